// File: rtl/mask_serializer_pkg.sv
// -----------------------------------------------------------------------------
// mask_serializer_pkg
// Shared definitions for the mask operand serializer:
//   - block geometry (BLOCK_SIZE, index width)
//   - bit offsets/widths of the fields inside the 64-bit matcher result
//   - serializer state enum
//   - popcount helper for 16-bit masks
// -----------------------------------------------------------------------------
package mask_serializer_pkg;

  localparam int BLOCK_SIZE = 16;
  localparam int IDX_W      = 4;

  // Matcher result layout
  localparam int MASK_W     = 16;
  localparam int W_MASK_LSB = 0;
  localparam int A_MASK_LSB = 16;
  localparam int NUM_W      = 5;
  localparam int NUMW_LSB   = 32;
  localparam int NUMA_LSB   = 40;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // Number of set bits in a 16-bit mask
  function automatic logic [4:0] popcount16(input logic [BLOCK_SIZE-1:0] m);
    logic [4:0] cnt;
    cnt = 5'd0;
    for (int i = 0; i < BLOCK_SIZE; i++) begin
      cnt = cnt + {4'd0, m[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/mask_operand_serializer_select.sv
// -----------------------------------------------------------------------------
// lowest_set_bits_select
// Picks the lowest LANES set bits of a 16-bit mask (LSB first).
// Ports:
//   mask    : input mask
//   idx     : idx[k] = bit position of the k-th set bit
//   valid   : valid[k] = 1 when a k-th set bit exists (contiguous from lane 0)
//   cleared : mask with the selected bits removed
// -----------------------------------------------------------------------------
module lowest_set_bits_select
  import mask_serializer_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic [BLOCK_SIZE-1:0]             mask,
  output logic [LANES-1:0][IDX_W-1:0]       idx,
  output logic [LANES-1:0]                  valid,
  output logic [BLOCK_SIZE-1:0]             cleared
);

  // rank_s[i] = number of set bits strictly below position i
  logic [BLOCK_SIZE-1:0][4:0] rank_s;

  // Prefix popcount giving each bit its rank among the set bits
  always_comb begin
    logic [4:0] cnt_v;
    cnt_v  = 5'd0;
    rank_s = {(BLOCK_SIZE*5){1'b0}};
    for (int i = 0; i < BLOCK_SIZE; i++) begin
      rank_s[i] = cnt_v;
      cnt_v     = cnt_v + {4'd0, mask[i]};
    end
  end

  // Lane k takes the set bit whose rank equals k; ranks below LANES are consumed
  always_comb begin
    logic hit_v;
    idx     = {(LANES*IDX_W){1'b0}};
    valid   = {LANES{1'b0}};
    cleared = {BLOCK_SIZE{1'b0}};
    for (int k = 0; k < LANES; k++) begin
      for (int i = 0; i < BLOCK_SIZE; i++) begin
        hit_v    = mask[i] & (rank_s[i] == 5'(k));
        idx[k]   = hit_v ? IDX_W'(i) : idx[k];
        valid[k] = valid[k] | hit_v;
      end
    end
    for (int i = 0; i < BLOCK_SIZE; i++) begin
      cleared[i] = mask[i] & (rank_s[i] >= 5'(LANES));
    end
  end

endmodule

// File: rtl/mask_operand_serializer.sv
// -----------------------------------------------------------------------------
// mask_operand_serializer
// Registers one mask-matcher result plus the block's compressed weight and
// activation arrays, then streams matched (weight, activation) pairs, up to
// LANES per beat, with out_last marking the final beat of each block.
//
// Ports:
//   clock, resetn            : clock, asynchronous active-low reset
//   in_valid/in_ready        : block handshake (in_ready is combinational so a
//                              new block can load on the last-beat handshake)
//   in_result[63:0]          : [15:0] W mask, [31:16] A mask, numW/numA ignored
//   in_weights, in_acts      : 16 compressed operands, element k at k*DATA_W
//   out_valid/out_ready      : beat handshake
//   out_weights, out_acts    : lane j at j*DATA_W, unused lanes are 0
//   out_lane_mask            : valid lanes, contiguous from lane 0
//   out_last                 : final beat of the current block
//   err_mismatch             : sticky, popcount(W) != popcount(A) on a load
//
// Build option MASK_SERIALIZER_EMPTY_SKIP_EN:
//   defined   : zero-pair blocks are swallowed without an output beat
//   undefined : zero-pair blocks emit one beat with lane mask 0 and out_last 1
//
// All out_* data are registered: the registers hold the beat being offered and
// the mask registers hold what remains after that beat.
// -----------------------------------------------------------------------------
module mask_operand_serializer
  import mask_serializer_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int DATA_W = 8
) (
  input  logic                         clock,
  input  logic                         resetn,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [63:0]                  in_result,
  input  logic [BLOCK_SIZE*DATA_W-1:0] in_weights,
  input  logic [BLOCK_SIZE*DATA_W-1:0] in_acts,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [LANES*DATA_W-1:0]      out_weights,
  output logic [LANES*DATA_W-1:0]      out_acts,
  output logic [LANES-1:0]             out_lane_mask,
  output logic                         out_last,
  output logic                         err_mismatch
);

`ifdef MASK_SERIALIZER_EMPTY_SKIP_EN
  localparam logic SKIP_EMPTY = 1'b1;
`else
  localparam logic SKIP_EMPTY = 1'b0;
`endif

  typedef logic [BLOCK_SIZE-1:0][DATA_W-1:0] block_arr_t;
  typedef logic [LANES-1:0][DATA_W-1:0]      lane_arr_t;

  state_e                  state_r, state_nxt_s;
  logic [BLOCK_SIZE-1:0]   rem_w_r, rem_a_r, rem_w_nxt_s, rem_a_nxt_s;
  block_arr_t              wts_r, acts_r, wts_nxt_s, acts_nxt_s;
  logic                    out_valid_r, out_valid_nxt_s;
  logic                    out_last_r, out_last_nxt_s;
  logic [LANES-1:0]        out_mask_r, out_mask_nxt_s;
  lane_arr_t               out_w_r, out_a_r, out_w_nxt_s, out_a_nxt_s;
  logic                    err_r, err_nxt_s;

  logic                    fire_s, last_fire_s, advance_s, load_s, emit_s;
  logic                    mismatch_s, skip_s;
  logic [BLOCK_SIZE-1:0]   src_w_s, src_a_s, clr_w_s, clr_a_s;
  block_arr_t              src_wts_s, src_acts_s;
  logic [LANES-1:0][IDX_W-1:0] idx_w_s, idx_a_s;
  logic [LANES-1:0]        vld_w_s, vld_a_s, beat_mask_s;
  lane_arr_t               beat_w_s, beat_a_s;
  logic                    beat_last_s, beat_empty_s;
  logic                    unused_s;

  assign unused_s = ^in_result[63:32];   // numW/numA fields are informational

  assign fire_s      = out_valid_r & out_ready;
  assign last_fire_s = fire_s & out_last_r;
  assign advance_s   = fire_s & ~out_last_r;
  assign in_ready    = (state_r == IDLE) | last_fire_s;
  assign load_s      = in_valid & in_ready;

  assign mismatch_s = popcount16(in_result[W_MASK_LSB +: MASK_W])
                   != popcount16(in_result[A_MASK_LSB +: MASK_W]);

  // The selectors look at the incoming block on a load, otherwise at the
  // remaining masks of the block in flight.
  assign src_w_s    = load_s ? in_result[W_MASK_LSB +: MASK_W] : rem_w_r;
  assign src_a_s    = load_s ? in_result[A_MASK_LSB +: MASK_W] : rem_a_r;
  assign src_wts_s  = load_s ? block_arr_t'(in_weights) : wts_r;
  assign src_acts_s = load_s ? block_arr_t'(in_acts)    : acts_r;

  lowest_set_bits_select #(.LANES(LANES)) u_sel_w (
    .mask    (src_w_s),
    .idx     (idx_w_s),
    .valid   (vld_w_s),
    .cleared (clr_w_s)
  );

  lowest_set_bits_select #(.LANES(LANES)) u_sel_a (
    .mask    (src_a_s),
    .idx     (idx_a_s),
    .valid   (vld_a_s),
    .cleared (clr_a_s)
  );

  // Both valid vectors are contiguous from lane 0, so the AND is min(nW, nA).
  assign beat_mask_s  = vld_w_s & vld_a_s;
  assign beat_empty_s = ~beat_mask_s[0];
  // Last beat once either mask runs out; surplus bits of the other are dropped.
  assign beat_last_s  = (clr_w_s == 16'h0000) | (clr_a_s == 16'h0000);
  assign skip_s       = beat_empty_s & SKIP_EMPTY;
  assign emit_s       = (load_s & ~skip_s) | advance_s;

  // Gather the selected operand pairs onto lanes, zeroing unused lanes
  always_comb begin
    beat_w_s = {(LANES*DATA_W){1'b0}};
    beat_a_s = {(LANES*DATA_W){1'b0}};
    for (int j = 0; j < LANES; j++) begin
      if (beat_mask_s[j]) begin
        beat_w_s[j] = src_wts_s[idx_w_s[j]];
        beat_a_s[j] = src_acts_s[idx_a_s[j]];
      end else begin
        beat_w_s[j] = {DATA_W{1'b0}};
        beat_a_s[j] = {DATA_W{1'b0}};
      end
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (load_s) begin
          state_nxt_s = skip_s ? IDLE : BUSY;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      BUSY: begin
        if (last_fire_s) begin
          if (load_s) begin
            state_nxt_s = skip_s ? IDLE : BUSY;
          end else begin
            state_nxt_s = IDLE;
          end
        end else begin
          state_nxt_s = BUSY;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Datapath next values: load operands, present a new beat, or retire
  always_comb begin
    rem_w_nxt_s     = rem_w_r;
    rem_a_nxt_s     = rem_a_r;
    wts_nxt_s       = wts_r;
    acts_nxt_s      = acts_r;
    out_valid_nxt_s = out_valid_r;
    out_last_nxt_s  = out_last_r;
    out_mask_nxt_s  = out_mask_r;
    out_w_nxt_s     = out_w_r;
    out_a_nxt_s     = out_a_r;
    err_nxt_s       = err_r;

    if (load_s) begin
      wts_nxt_s  = block_arr_t'(in_weights);
      acts_nxt_s = block_arr_t'(in_acts);
      err_nxt_s  = err_r | mismatch_s;
    end else begin
      err_nxt_s  = err_r;
    end

    if (emit_s) begin
      rem_w_nxt_s     = clr_w_s;
      rem_a_nxt_s     = clr_a_s;
      out_valid_nxt_s = 1'b1;
      out_last_nxt_s  = beat_last_s;
      out_mask_nxt_s  = beat_mask_s;
      out_w_nxt_s     = beat_w_s;
      out_a_nxt_s     = beat_a_s;
    end else if (last_fire_s | load_s) begin
      // final beat consumed (or empty block swallowed) with nothing to show
      out_valid_nxt_s = 1'b0;
      out_last_nxt_s  = 1'b0;
      out_mask_nxt_s  = {LANES{1'b0}};
      out_w_nxt_s     = {(LANES*DATA_W){1'b0}};
      out_a_nxt_s     = {(LANES*DATA_W){1'b0}};
    end else begin
      out_valid_nxt_s = out_valid_r;
    end
  end

  // State and datapath registers
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_r     <= IDLE;
      rem_w_r     <= 16'h0000;
      rem_a_r     <= 16'h0000;
      wts_r       <= {(BLOCK_SIZE*DATA_W){1'b0}};
      acts_r      <= {(BLOCK_SIZE*DATA_W){1'b0}};
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      out_mask_r  <= {LANES{1'b0}};
      out_w_r     <= {(LANES*DATA_W){1'b0}};
      out_a_r     <= {(LANES*DATA_W){1'b0}};
      err_r       <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      rem_w_r     <= rem_w_nxt_s;
      rem_a_r     <= rem_a_nxt_s;
      wts_r       <= wts_nxt_s;
      acts_r      <= acts_nxt_s;
      out_valid_r <= out_valid_nxt_s;
      out_last_r  <= out_last_nxt_s;
      out_mask_r  <= out_mask_nxt_s;
      out_w_r     <= out_w_nxt_s;
      out_a_r     <= out_a_nxt_s;
      err_r       <= err_nxt_s;
    end
  end

  assign out_valid     = out_valid_r;
  assign out_last      = out_last_r;
  assign out_lane_mask = out_mask_r;
  assign out_weights   = out_w_r;
  assign out_acts      = out_a_r;
  assign err_mismatch  = err_r;

endmodule
